muldiv_sched: RTL and testbench

//  Sequencer and owner of the HI/LO pair for all multiply/divide-class ops from decode
//  (MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MUL/MTHI/MTLO).

---
 rtl/muldiv_sched.sv | 167 ++++++++++++++++
 tb/tb_muldiv_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencer and HI/LO owner for the multiply/divide op class.
// One op at a time: a timed multi-cycle multiplier (with optional HI/LO
// accumulate) and a 32-step restoring divider. MTHI/MTLO write HI/LO directly.
module muldiv_sched #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  state_t      state;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  cnt;
  // Product / accumulator result, or {remainder, quotient} while dividing.
  logic [63:0] res;

  logic        is_signed;
  logic        is_acc;
  logic        is_sub;
  logic        is_sdiv;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] dvs;
  logic [31:0] req_a_mag;
  logic [32:0] div_shift;
  logic        div_fits;
  logic [31:0] div_rem_sub;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Op codes 0..8 are signed exactly when bit 0 is clear (MUL is signed too).
  assign is_signed = ~op[0];
  assign is_acc    = (op == 4'd4) || (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
  assign is_sub    = (op == 4'd6) || (op == 4'd7);
  assign is_sdiv   = (op == 4'd2);

  // The latched operands are stable for MUL_LAT cycles, so this multiply
  // is allowed to be a multicycle path.
  assign ext_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign ext_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign product = ext_a * ext_b;

  // Divider works on magnitudes; the sign fixup is applied at commit.
  assign dvs       = (is_sdiv && b[31]) ? -b : b;
  assign req_a_mag = ((req_op == 4'd2) && req_a[31]) ? -req_a : req_a;

  assign div_shift   = {res[63:32], res[31]};
  assign div_fits    = div_shift >= {1'b0, dvs};
  assign div_rem_sub = div_shift[31:0] - dvs;
  assign div_next    = div_fits ? {div_rem_sub, res[30:0], 1'b1}
                                : {div_shift[31:0], res[30:0], 1'b0};

  assign quo_fix = (is_sdiv && (a[31] ^ b[31])) ? -res[31:0] : res[31:0];
  assign rem_fix = (is_sdiv && a[31]) ? -res[63:32] : res[63:32];

  assign busy       = (state != S_IDLE);
  assign req_ready  = (state == S_IDLE) && !flush;
  assign resp_valid = (state == S_DONE) && !flush;
  assign resp_data  = (resp_valid && (op == 4'd8)) ? res[31:0] : 32'd0;

  // Sequencer: accept, time the multiplier, step the divider, commit HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      op    <= 4'd0;
      a     <= 32'd0;
      b     <= 32'd0;
      cnt   <= 5'd0;
      res   <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op <= req_op;
            a  <= req_a;
            b  <= req_b;
            case (req_op)
              4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                state <= S_MUL;
                cnt   <= MUL_CNT;
              end
              4'd2, 4'd3: begin
                state <= S_DIV;
                cnt   <= 5'd31;
                res   <= {32'd0, req_a_mag};
              end
              4'd9:    hi <= req_a;
              4'd10:   lo <= req_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == 5'd0) begin
            res   <= product;
            state <= is_acc ? S_ACC : S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_ACC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            res   <= is_sub ? ({hi, lo} - res) : ({hi, lo} + res);
            state <= S_DONE;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            res <= div_next;
            if (cnt == 5'd0) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!flush) begin
            if (op == 4'd2 || op == 4'd3) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else if (op != 4'd8) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: vector table plus hand-written flush/reset/back-to-back
// sequences; responses are matched against a scoreboard queue.
module tb_muldiv_sched;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .hi         (hi),
    .lo         (lo)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurement.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    int          lat;
  } sb_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_data;
    int          exp_lat;
    bit          has_resp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[17];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every response must match the oldest scoreboard entry in data and latency.
  always @(negedge clk) begin
    if (resetn && resp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 data %h expected no response", resp_data);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        checkOutput("resp_data", resp_data, e.data);
        checkOutput("resp_latency", 32'(cyc + 1 - e.acc_cyc), 32'(e.lat));
      end
    end
  end

  // Present one request, hold until accepted, optionally log the expected response.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit has_resp, input logic [31:0] exp_data, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    if (has_resp) sbq.push_back('{exp_data, cyc, exp_lat});
    req_valid = 1'b0;
  endtask

  // Wait for the op to retire; req_ready must stay low the whole time.
  task automatic waitIdle(input string name);
    int n;
    bit ready_seen;
    n = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (req_ready) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_ready_while_busy"}, {31'd0, ready_seen}, 32'd0);
  endtask

  // Main test sequence.
  initial begin
    int acc_at[2];
    int got;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0,       MUL_LAT+1, 1'b1};
    vecs[1]  = '{4'd1,  32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 32'd0,       MUL_LAT+1, 1'b1};
    vecs[2]  = '{4'd9,  32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFA, 32'd0,       0,         1'b0};
    vecs[3]  = '{4'd10, 32'd7,         32'd0,        32'h0000_0005, 32'h0000_0007, 32'd0,       0,         1'b0};
    vecs[4]  = '{4'd4,  32'd2,         32'd3,        32'h0000_0005, 32'h0000_000D, 32'd0,       MUL_LAT+2, 1'b1};
    vecs[5]  = '{4'd7,  32'd1,         32'd14,       32'h0000_0004, 32'hFFFF_FFFF, 32'd0,       MUL_LAT+2, 1'b1};
    vecs[6]  = '{4'd2,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0,       33,        1'b1};
    vecs[7]  = '{4'd3,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 32'd0,       33,        1'b1};
    vecs[8]  = '{4'd8,  32'h0001_0000, 32'h0001_0000, 32'h0000_0007, 32'hFFFF_FFFF, 32'd0,      MUL_LAT+1, 1'b1};
    vecs[9]  = '{4'd8,  32'h0000_1234, 32'h0000_0010, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0001_2340, MUL_LAT+1, 1'b1};
    vecs[10] = '{4'd2,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'd0,      33,        1'b1};
    vecs[11] = '{4'd6,  32'd3,         32'hFFFF_FFFE, 32'h0000_0000, 32'h8000_0006, 32'd0,      MUL_LAT+2, 1'b1};
    vecs[12] = '{4'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0007, 32'd0,      MUL_LAT+2, 1'b1};
    vecs[13] = '{4'd12, 32'd99,        32'd98,       32'hFFFF_FFFE, 32'h8000_0007, 32'd0,       0,         1'b0};
    vecs[14] = '{4'd2,  32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 32'd0,       33,        1'b1};
    vecs[15] = '{4'd2,  32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'h0000_0001, 32'd0,       33,        1'b1};
    vecs[16] = '{4'd2,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 32'd0,      33,        1'b1};

    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    flush     = 1'b0;

    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].has_resp, vecs[i].exp_data, vecs[i].exp_lat);
      waitIdle($sformatf("v%0d", i));
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Flush a divide mid-flight; then a request during flush-in-IDLE is refused.
    applyStimulus(4'd2, 32'd100, 32'd7, 1'b0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_div_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush_div_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_idle_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_op    = 4'd9;
    req_a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_div_hi", hi, 32'h0000_0002);
    checkOutput("flush_div_lo", lo, 32'hFFFF_FFF2);
    applyStimulus(4'd10, 32'h55, 32'd0, 1'b0, 32'd0, 0);
    waitIdle("after_flush");
    checkOutput("after_flush_lo", lo, 32'h0000_0055);
    checkOutput("after_flush_hi", hi, 32'h0000_0002);

    // Flush while in DONE: response suppressed, no commit.
    applyStimulus(4'd0, 32'd2, 32'd2, 1'b0, 32'd0, 0);
    repeat (MUL_LAT) @(posedge clk);
    #1 flush = 1'b1;
    #1 checkOutput("flush_done_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    waitIdle("flush_done");
    checkOutput("flush_done_hi", hi, 32'h0000_0002);
    checkOutput("flush_done_lo", lo, 32'h0000_0055);

    // Flush while in ACC: accumulate discarded.
    applyStimulus(4'd4, 32'd1, 32'd1, 1'b0, 32'd0, 0);
    repeat (MUL_LAT) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    waitIdle("flush_acc");
    checkOutput("flush_acc_hi", hi, 32'h0000_0002);
    checkOutput("flush_acc_lo", lo, 32'h0000_0055);

    // Back-to-back MULTs with req_valid held high.
    got = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd0;
    req_a     = 32'd3;
    req_b     = 32'd4;
    for (int n = 0; n < 40 && got < 2; n++) begin
      if (n != 0) @(negedge clk);
      if (req_ready) begin
        acc_at[got] = cyc + 1;
        sbq.push_back('{32'd0, cyc + 1, MUL_LAT + 1});
        got++;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("b2b_accepts", 32'(got), 32'd2);
    if (got == 2) checkOutput("b2b_spacing", 32'(acc_at[1] - acc_at[0]), 32'(MUL_LAT + 2));
    waitIdle("b2b");
    checkOutput("b2b_hi", hi, 32'd0);
    checkOutput("b2b_lo", lo, 32'd12);

    // Reset in the middle of a divide.
    applyStimulus(4'd2, 32'd100, 32'd7, 1'b0, 32'd0, 0);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midrst_resp_data", resp_data, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(4'd9, 32'd9, 32'd0, 1'b0, 32'd0, 0);
    waitIdle("post_rst");
    checkOutput("post_rst_hi", hi, 32'd9);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
